// File: rtl/redmule_job_scheduler.sv
// -----------------------------------------------------------------------------
// redmule_job_scheduler
//
// Queues complete GEMM jobs (NumCfgRegs config words each) handed over by the
// X-IF issue decode path. Each job is written into the RedMulE register file
// over the hwpe periph port: all config words first, then the trigger. The
// next job is held back until the engine reports done.
//
// Optional feature macro: REDMULE_SCHED_JOBCNT_EN
//   defined   -> jobs_done_o is a wrapping 32-bit count of completed jobs
//   undefined -> jobs_done_o is tied to zero and no counter flops exist
//
// Handshakes:
//   job side    : a job is accepted on a rising edge where job_valid_i and
//                 job_ready_o are both high. job_ready_o depends only on FIFO
//                 occupancy, never on job_valid_i.
//   periph side : a write completes on a rising edge where periph_req_o and
//                 periph_gnt_i are both high. While req is high without gnt,
//                 periph_add_o/periph_data_o hold their value.
//
// dbg_state_o exposes the FSM state: 0 IDLE, 1 WRITE, 2 TRIGGER, 3 WAIT_DONE.
// -----------------------------------------------------------------------------
module redmule_job_scheduler #(
    parameter int unsigned          DataWidth  = 32,
    parameter int unsigned          AddrWidth  = 32,
    parameter int unsigned          NumCfgRegs = 6,
    parameter int unsigned          Depth      = 2,
    parameter logic [AddrWidth-1:0] CfgBase    = 'h40,
    parameter logic [AddrWidth-1:0] TrigAddr   = 'h0
) (
    input  logic                             clk_int,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    // job input from the issue path
    input  logic                             job_valid_i,
    output logic                             job_ready_o,
    input  logic [NumCfgRegs*DataWidth-1:0]  job_cfg_i,
    // hwpe periph write port
    output logic                             periph_req_o,
    output logic                             periph_wen_o,
    output logic [DataWidth/8-1:0]           periph_be_o,
    output logic [AddrWidth-1:0]             periph_add_o,
    output logic [DataWidth-1:0]             periph_data_o,
    input  logic                             periph_gnt_i,
    // engine status
    input  logic                             cfg_complete_i,
    input  logic                             done_evt_i,
    // status
    output logic                             start_cfg_o,
    output logic                             busy_o,
    output logic [$clog2(Depth):0]           pending_o,
    output logic [31:0]                      jobs_done_o,
    output logic [1:0]                       dbg_state_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned OccW = PtrW + 1;
    localparam int unsigned CntW = (NumCfgRegs > 1) ? $clog2(NumCfgRegs) : 1;

    localparam logic [CntW-1:0] LastCnt  = CntW'(NumCfgRegs - 1);
    localparam logic [OccW-1:0] FullOcc  = OccW'(Depth);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
    localparam logic [OccW-1:0] OccOne   = OccW'(1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        TRIGGER   = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // Storage and bookkeeping registers
    // -------------------------------------------------------------------------
    logic [DataWidth-1:0] mem_q [Depth][NumCfgRegs];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]      occ_q, occ_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    state_e               state_q, state_d;

    logic push_en;
    logic pop_en;
    logic fifo_full;
    logic fifo_empty;

    assign fifo_full  = (occ_q == FullOcc);
    assign fifo_empty = (occ_q == '0);

    // A full FIFO never accepts, even when the head is popped in the same cycle.
    assign job_ready_o = !fifo_full;
    assign push_en     = job_valid_i && job_ready_o && !clear_i;

    // FIFO pointer and occupancy next-state; clear flushes everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            if (push_en && !pop_en) begin
                occ_d = occ_q + OccOne;
            end else if (!push_en && pop_en) begin
                occ_d = occ_q - OccOne;
            end
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Job payload storage; only slots between the pointers are ever read.
    always_ff @(posedge clk_int) begin
        if (push_en) begin
            for (int i = 0; i < NumCfgRegs; i++) begin
                mem_q[wr_ptr_q][i] <= job_cfg_i[i*DataWidth +: DataWidth];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequencing FSM
    // -------------------------------------------------------------------------
    logic                 req;
    logic [AddrWidth-1:0] add;
    logic [DataWidth-1:0] data;
    logic                 start_cfg;
    logic                 pop_req;

    // Next state and periph outputs; the head job stays in the FIFO until done.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req       = 1'b0;
        add       = '0;
        data      = '0;
        start_cfg = 1'b0;
        pop_req   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Leave IDLE one cycle after the FIFO sees its first entry.
                if (!fifo_empty) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                req  = 1'b1;
                add  = CfgBase + AddrWidth'({cnt_q, 2'b00});
                data = mem_q[rd_ptr_q][cnt_q];
                if (periph_gnt_i) begin
                    if (cnt_q == LastCnt) begin
                        start_cfg = 1'b1;
                        cnt_d     = '0;
                        state_d   = TRIGGER;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end
            TRIGGER: begin
                // The trigger may only be issued once the engine has the config.
                if (cfg_complete_i) begin
                    req  = 1'b1;
                    add  = TrigAddr;
                    data = '0;
                    if (periph_gnt_i) begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (done_evt_i) begin
                    pop_req = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over grant and done; a partial config is dropped.
        if (clear_i) begin
            state_d   = IDLE;
            cnt_d     = '0;
            req       = 1'b0;
            add       = '0;
            data      = '0;
            start_cfg = 1'b0;
            pop_req   = 1'b0;
        end
    end

    // FSM state and word counter registers.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pop_en = pop_req;

    assign periph_req_o  = req;
    assign periph_wen_o  = 1'b0;
    assign periph_be_o   = req ? '1 : '0;
    assign periph_add_o  = add;
    assign periph_data_o = data;
    assign start_cfg_o   = start_cfg;

    assign busy_o      = (state_q != IDLE) || !fifo_empty;
    assign pending_o   = occ_q;
    assign dbg_state_o = state_q;

    // -------------------------------------------------------------------------
    // Completed-job counter
    // -------------------------------------------------------------------------
`ifdef REDMULE_SCHED_JOBCNT_EN
    logic [31:0] jobs_done_q, jobs_done_d;

    // Count done pops; wraps naturally at 2^32.
    always_comb begin
        jobs_done_d = jobs_done_q;
        if (clear_i) begin
            jobs_done_d = '0;
        end else if (pop_en) begin
            jobs_done_d = jobs_done_q + 32'd1;
        end
    end

    // Completed-job counter register.
    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            jobs_done_q <= '0;
        end else begin
            jobs_done_q <= jobs_done_d;
        end
    end

    assign jobs_done_o = jobs_done_q;
`else
    assign jobs_done_o = '0;
`endif

endmodule

// File: tb/tb_redmule_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_redmule_job_scheduler
//
// Directed scenarios followed by a randomized phase. A reference model kept at
// job level (number of queued jobs, handshakes completed for the head job and
// a queue of expected periph writes) is updated on every falling edge and every
// DUT output is compared against it there.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_redmule_job_scheduler;

  localparam int N        = 6;
  localparam int DEPTH    = 2;
  localparam int DW       = 32;
  localparam int CFG_BASE = 'h40;
  localparam int W        = N * DW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk_int = 1'b0;
  logic rst_ni  = 1'b0;
  always #5 clk_int = ~clk_int;

  int cyc = 0;
  always @(posedge clk_int) cyc++;

  // DUT signals
  logic          clear_i        = 1'b0;
  logic          job_valid_i    = 1'b0;
  logic          job_ready_o;
  logic [W-1:0]  job_cfg_i      = '0;
  logic          periph_req_o;
  logic          periph_wen_o;
  logic [3:0]    periph_be_o;
  logic [31:0]   periph_add_o;
  logic [31:0]   periph_data_o;
  logic          periph_gnt_i   = 1'b0;
  logic          cfg_complete_i = 1'b0;
  logic          done_evt_i     = 1'b0;
  logic          start_cfg_o;
  logic          busy_o;
  logic [1:0]    pending_o;
  logic [31:0]   jobs_done_o;
  logic [1:0]    dbg_state_o;

  redmule_job_scheduler dut (
    .clk_int        (clk_int),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .job_valid_i    (job_valid_i),
    .job_ready_o    (job_ready_o),
    .job_cfg_i      (job_cfg_i),
    .periph_req_o   (periph_req_o),
    .periph_wen_o   (periph_wen_o),
    .periph_be_o    (periph_be_o),
    .periph_add_o   (periph_add_o),
    .periph_data_o  (periph_data_o),
    .periph_gnt_i   (periph_gnt_i),
    .cfg_complete_i (cfg_complete_i),
    .done_evt_i     (done_evt_i),
    .start_cfg_o    (start_cfg_o),
    .busy_o         (busy_o),
    .pending_o      (pending_o),
    .jobs_done_o    (jobs_done_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model / scoreboard
  // ---------------------------------------------------------------------------
  int          m_jobs = 0;   // jobs held, including the active one
  int          m_acc  = 0;   // completed periph writes of the head job (0..N+1)
  logic [31:0] m_done = '0;
  logic [63:0] exp_q[$];     // {addr, data} of every write still owed
  int          cnt48  = 0;   // cycles with a request on cfg word 2

  always @(negedge clk_int) begin
    if (rst_ni) begin
      logic do_pop;
      logic do_push;
      check_eq("pending",   pending_o,    m_jobs);
      check_eq("job_ready", job_ready_o,  m_jobs < DEPTH);
      check_eq("busy",      busy_o,       m_jobs != 0);
      check_eq("jobs_done", jobs_done_o,  m_done);
      check_eq("wen",       periph_wen_o, 0);
      check_eq("be",        periph_be_o,  periph_req_o ? 4'hF : 4'h0);
      if (clear_i) begin
        check_eq("clear_req",   periph_req_o, 0);
        check_eq("clear_start", start_cfg_o,  0);
        m_jobs = 0;
        m_acc  = 0;
        m_done = '0;
        exp_q.delete();
      end else begin
        if (m_jobs == 0)          check_eq("req_empty",   periph_req_o, 0);
        else if (m_acc == N)      check_eq("req_trigger", periph_req_o, cfg_complete_i);
        else if (m_acc == N + 1)  check_eq("req_wait",    periph_req_o, 0);
        else if (m_acc > 0)       check_eq("req_write",   periph_req_o, 1);
        if (periph_req_o) begin
          check_eq("exp_avail", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            check_eq("add",  periph_add_o,  exp_q[0][63:32]);
            check_eq("data", periph_data_o, exp_q[0][31:0]);
          end
          if (periph_add_o == 32'h48) cnt48++;
        end
        check_eq("start_cfg", start_cfg_o,
                 m_jobs > 0 && m_acc == N - 1 && periph_req_o && periph_gnt_i);
        do_pop  = done_evt_i && m_jobs > 0 && m_acc == N + 1;
        do_push = job_valid_i && m_jobs < DEPTH;
        if (periph_req_o && periph_gnt_i && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          m_acc++;
        end
        if (do_pop) begin
          m_jobs--;
          m_acc = 0;
`ifdef REDMULE_SCHED_JOBCNT_EN
          m_done = m_done + 32'd1;
`endif
        end
        if (do_push) begin
          m_jobs++;
          for (int i = 0; i < N; i++) begin
            logic [31:0] a;
            a = CFG_BASE + 4 * i;
            exp_q.push_back({a, job_cfg_i[i*DW +: DW]});
          end
          exp_q.push_back(64'h0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Grant responder: 0 always, 1 random, 2 stall word 2 for 3 cycles,
  // 4 stall forever on word 3
  // ---------------------------------------------------------------------------
  int gnt_mode  = 0;
  int stall_cnt = 0;
  always @(posedge clk_int) begin
    #1;
    case (gnt_mode)
      1: periph_gnt_i = 1'($urandom_range(0, 1));
      2: begin
        if (periph_req_o && periph_add_o == 32'h48 && stall_cnt < 3) begin
          periph_gnt_i = 1'b0;
          stall_cnt++;
        end else begin
          periph_gnt_i = 1'b1;
        end
      end
      4: periph_gnt_i = !(periph_req_o && periph_add_o == 32'h4C);
      default: periph_gnt_i = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_int);
    #1;
  endtask

  function automatic logic [W-1:0] rand_job();
    logic [W-1:0] j;
    for (int i = 0; i < N; i++) j[i*DW +: DW] = $urandom();
    return j;
  endfunction

  // Offer a job until accepted; acc_cyc is the cycle whose closing edge took it.
  task automatic push_job(input logic [W-1:0] cfg, output int acc_cyc);
    bit hit;
    hit         = 0;
    acc_cyc     = -1;
    job_valid_i = 1'b1;
    job_cfg_i   = cfg;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_int);
      if (job_ready_o) begin
        hit     = 1;
        acc_cyc = cyc;
        break;
      end
    end
    tick();
    job_valid_i = 1'b0;
    check_eq("push_accepted", hit, 1);
  endtask

  task automatic wait_acc(input int target, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_jobs > 0 && m_acc == target) begin
        hit = 1;
        break;
      end
      tick();
    end
    check_eq({tag, "_reached"}, hit, 1);
  endtask

  task automatic pulse_done(output int dc);
    dc         = cyc;
    done_evt_i = 1'b1;
    tick();
    done_evt_i = 1'b0;
  endtask

  task automatic drain();
    int dc;
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (m_jobs == 0) break;
      wait_acc(N + 1, "drain");
      pulse_done(dc);
    end
    @(negedge clk_int);
    check_eq("drain_pending", pending_o, 0);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int c1, c2, c3, dc, tcyc;
    logic [W-1:0] job;
    logic [31:0]  done_snap;

    // reset state
    repeat (2) @(negedge clk_int);
    check_eq("rst_pending",   pending_o,    0);
    check_eq("rst_ready",     job_ready_o,  1);
    check_eq("rst_req",       periph_req_o, 0);
    check_eq("rst_be",        periph_be_o,  0);
    check_eq("rst_add",       periph_add_o, 0);
    check_eq("rst_start",     start_cfg_o,  0);
    check_eq("rst_busy",      busy_o,       0);
    check_eq("rst_jobs_done", jobs_done_o,  0);
    tick();
    rst_ni = 1'b1;
    tick();

    // one job, words 0x11..0x66, gnt always, cfg_complete late
    gnt_mode = 0;
    cfg_complete_i = 1'b0;
    for (int i = 0; i < N; i++) job[i*DW +: DW] = 32'((i + 1) * 'h11);
    push_job(job, c1);
    @(negedge clk_int);
    check_eq("lat_n1_req",     periph_req_o, 0);
    check_eq("lat_n1_pending", pending_o,    1);
    @(negedge clk_int);
    check_eq("lat_n2_req",     periph_req_o, 1);
    check_eq("lat_n2_add",     periph_add_o, 32'h40);
    tick();
    wait_acc(N, "job1_trigger");
    tcyc = cyc;
    check_eq("write_span", tcyc, c1 + 2 + N);
    repeat (3) tick();
    cfg_complete_i = 1'b1;
    wait_acc(N + 1, "job1_wait");
    @(negedge clk_int);
    check_eq("job1_pending_before", pending_o, 1);
    tick();
    pulse_done(dc);
    @(negedge clk_int);
    check_eq("job1_pending_after", pending_o, 0);
    tick();

    // gnt low 3 cycles on word 2; done pulsed in WRITE and in TRIGGER
    gnt_mode       = 2;
    stall_cnt      = 0;
    cnt48          = 0;
    cfg_complete_i = 1'b0;
    push_job(rand_job(), c1);
    wait_acc(2, "stall_word2");
    done_snap = m_done;
    pulse_done(dc);
    @(negedge clk_int);
    check_eq("done_in_write_pending", pending_o,   1);
    check_eq("done_in_write_count",   jobs_done_o, done_snap);
    tick();
    wait_acc(N, "stall_trigger");
    tick();
    pulse_done(dc);
    @(negedge clk_int);
    check_eq("done_in_trigger_pending", pending_o,   1);
    check_eq("done_in_trigger_count",   jobs_done_o, done_snap);
    tick();
    cfg_complete_i = 1'b1;
    drain();
    check_eq("word2_stable_cycles", cnt48, 4);
    gnt_mode = 0;

    // three jobs back-to-back into a two-entry FIFO
    push_job(rand_job(), c1);
    push_job(rand_job(), c2);
    @(negedge clk_int);
    check_eq("full_ready", job_ready_o, 0);
    tick();
    fork
      push_job(rand_job(), c3);
      begin
        wait_acc(N + 1, "b2b_first");
        pulse_done(dc);
      end
    join
    check_eq("third_accept_cycle", c3, dc + 1);
    drain();

    // clear while writing word 3 with two jobs queued
    gnt_mode = 4;
    push_job(rand_job(), c1);
    push_job(rand_job(), c2);
    wait_acc(3, "clear_word3");
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    @(negedge clk_int);
    check_eq("post_clear_req",     periph_req_o, 0);
    check_eq("post_clear_pending", pending_o,    0);
    check_eq("post_clear_ready",   job_ready_o,  1);
    check_eq("post_clear_state",   dbg_state_o,  0);
    tick();
    gnt_mode = 0;

    // completed-job counter wrap
    push_job(rand_job(), c1);
    wait_acc(N + 1, "cnt_job");
`ifdef REDMULE_SCHED_JOBCNT_EN
    #1;
    force dut.jobs_done_q = 32'hFFFF_FFFF;
    m_done = 32'hFFFF_FFFF;
    #1;
    release dut.jobs_done_q;
    pulse_done(dc);
    @(negedge clk_int);
    check_eq("cnt_wrap", jobs_done_o, 0);
`else
    pulse_done(dc);
    @(negedge clk_int);
    check_eq("cnt_tied_zero", jobs_done_o, 0);
`endif
    tick();

    // randomized phase
    gnt_mode = 1;
    for (int i = 0; i < 600; i++) begin
      job_valid_i    = ($urandom_range(0, 1) == 0);
      job_cfg_i      = rand_job();
      cfg_complete_i = ($urandom_range(0, 2) != 0);
      done_evt_i     = ($urandom_range(0, 3) == 0);
      clear_i        = ($urandom_range(0, 99) == 0);
      tick();
    end
    job_valid_i    = 1'b0;
    done_evt_i     = 1'b0;
    clear_i        = 1'b0;
    cfg_complete_i = 1'b1;
    gnt_mode       = 0;
    tick();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
